// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the branch_predictor_bht slice.
//   seqState_e  : next-PC sequencer states (IDLE, PENDING)
//   TARGET_BITS : stored target width (target[31:2], word aligned)
//   clog2       : constant log2 used for index sizing
//   ctrMaxVal / ctrInitVal : saturation ceiling and allocation value
//   entryBits   : width of one BTB entry {valid, tag, target[31:2], ctr}
// ----------------------------------------------------------------------------
package bp_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } seqState_e;

   localparam int TARGET_BITS = 30;

   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 32'sd1;
      while (remaining > 32'sd0) begin
         result    = result + 32'sd1;
         remaining = remaining >>> 1;
      end
      return result;
   endfunction

   // Largest counter value: 2^ctrBits - 1.
   function automatic int ctrMaxVal(input int ctrBits);
      return (32'sd1 <<< ctrBits) - 32'sd1;
   endfunction

   // Newly allocated entries start weakly taken: 2^(ctrBits-1).
   function automatic int ctrInitVal(input int ctrBits);
      return 32'sd1 <<< (ctrBits - 32'sd1);
   endfunction

   function automatic int entryBits(input int tagBits, input int ctrBits);
      return 32'sd1 + tagBits + TARGET_BITS + ctrBits;
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// ----------------------------------------------------------------------------
// bp_sat_ctr
// Next-value logic for one CTR_BITS-wide saturating direction counter.
//   ctrCur : current counter value
//   up     : 1 = count toward taken, 0 = count toward not-taken
//   ctrNew : updated value, clamped to [0, 2^CTR_BITS-1]
// ----------------------------------------------------------------------------
module bp_sat_ctr
   import bp_pkg::*;
#(
   parameter int CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctrCur,
   input  logic                up,
   output logic [CTR_BITS-1:0] ctrNew
);

   localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctrMaxVal(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_ZERO = CTR_BITS'(0);
   localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

   // Saturating increment / decrement
   always_comb begin
      ctrNew = ctrCur;
      if (up) begin
         if (ctrCur != CTR_MAX) begin
            ctrNew = ctrCur + CTR_ONE;
         end else begin
            ctrNew = ctrCur;
         end
      end else begin
         if (ctrCur != CTR_ZERO) begin
            ctrNew = ctrCur - CTR_ONE;
         end else begin
            ctrNew = ctrCur;
         end
      end
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// ----------------------------------------------------------------------------
// branch_predictor_bht
// Direct-mapped tagged BTB with saturating direction counters and MIPS
// delay-slot aware next-PC sequencing for the IF stage.
//   clk, rst        : clock, synchronous active-high reset
//   stall           : freezes sequencer state and blocks training
//   exc_flush       : exception redirect; forces IDLE, blocks training
//   pc              : current IF PC
//   next_pc         : predicted next fetch PC (combinational)
//   pred_taken      : a taken prediction was issued for pc
//   res_*           : EX-stage branch resolution / training port
//   bp_flush        : mispredict, flush younger non-delay-slot instructions
//   redirect_pc     : correct fetch PC while bp_flush is high
// ----------------------------------------------------------------------------
module branch_predictor_bht
   import bp_pkg::*;
#(
   parameter int ENTRIES  = 64,
   parameter int CTR_BITS = 2,
   parameter int TAG_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        exc_flush,
   input  logic [31:0] pc,
   output logic [31:0] next_pc,
   output logic        pred_taken,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   input  logic        res_pred_taken,
   output logic        bp_flush,
   output logic [31:0] redirect_pc
);

   localparam int IDX_BITS = clog2(ENTRIES);
   localparam int TAG_LO   = IDX_BITS + 2;
   localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctrInitVal(CTR_BITS));

   typedef struct packed {
      logic                   valid;
      logic [TAG_BITS-1:0]    tag;
      logic [TARGET_BITS-1:0] target;
      logic [CTR_BITS-1:0]    ctr;
   } entry_t;

   // Storage split by field: only valid bits carry a reset.
   logic [ENTRIES-1:0]     validArr_r;
   logic [TAG_BITS-1:0]    tagArr_r    [ENTRIES];
   logic [TARGET_BITS-1:0] targetArr_r [ENTRIES];
   logic [CTR_BITS-1:0]    ctrArr_r    [ENTRIES];

   seqState_e              state_r;
   logic [TARGET_BITS-1:0] pendTarget_r;

   logic [IDX_BITS-1:0]    lookIdx_s;
   logic [TAG_BITS-1:0]    lookTag_s;
   entry_t                 lookEntry_s;
   logic                   lookTaken_s;

   logic [IDX_BITS-1:0]    resIdx_s;
   logic [TAG_BITS-1:0]    resTag_s;
   entry_t                 resEntry_s;
   logic                   resHit_s;
   logic                   wrongTarget_s;
   logic                   bpFlush_s;
   logic                   trainEn_s;
   logic [CTR_BITS-1:0]    ctrNew_s;

   assign lookIdx_s   = pc[IDX_BITS+1:2];
   assign lookTag_s   = pc[TAG_HI:TAG_LO];
   assign lookEntry_s = {validArr_r[lookIdx_s], tagArr_r[lookIdx_s],
                         targetArr_r[lookIdx_s], ctrArr_r[lookIdx_s]};
   assign lookTaken_s = lookEntry_s.valid & (lookEntry_s.tag == lookTag_s)
                      & lookEntry_s.ctr[CTR_BITS-1];

   assign resIdx_s    = res_pc[IDX_BITS+1:2];
   assign resTag_s    = res_pc[TAG_HI:TAG_LO];
   assign resEntry_s  = {validArr_r[resIdx_s], tagArr_r[resIdx_s],
                         targetArr_r[resIdx_s], ctrArr_r[resIdx_s]};
   assign resHit_s    = resEntry_s.valid & (resEntry_s.tag == resTag_s);

   // A predicted-taken, actually-taken branch still flushes when the entry
   // no longer supplies the resolved target (replaced or stale target).
   assign wrongTarget_s = res_taken & res_pred_taken
                        & ~(resHit_s & (resEntry_s.target == res_target[31:2]));
   assign bpFlush_s     = res_valid & ((res_taken != res_pred_taken) | wrongTarget_s);
   assign trainEn_s     = res_valid & ~stall & ~exc_flush;

   bp_sat_ctr #(
      .CTR_BITS (CTR_BITS)
   ) uSatCtr (
      .ctrCur (resEntry_s.ctr),
      .up     (res_taken),
      .ctrNew (ctrNew_s)
   );

   // Next-PC and misprediction outputs
   always_comb begin
      next_pc     = pc + 32'd4;
      pred_taken  = 1'b0;
      bp_flush    = bpFlush_s;
      redirect_pc = res_pc + 32'd8;
      if (state_r == PENDING) begin
         next_pc    = {pendTarget_r, 2'b00};
         pred_taken = 1'b0;
      end else begin
         next_pc    = pc + 32'd4;
         pred_taken = lookTaken_s & ~stall & ~exc_flush;
      end
      if (res_taken) begin
         redirect_pc = res_target;
      end else begin
         redirect_pc = res_pc + 32'd8;
      end
   end

   // Valid bits: cleared by reset, set on allocation
   always_ff @(posedge clk) begin
      if (rst) begin
         validArr_r <= '0;
      end else if (trainEn_s & ~resHit_s & res_taken) begin
         validArr_r[resIdx_s] <= 1'b1;
      end
   end

   // Entry payload: counter update on hit, full replace on taken miss
   always_ff @(posedge clk) begin
      if (trainEn_s) begin
         if (resHit_s) begin
            ctrArr_r[resIdx_s] <= ctrNew_s;
            if (res_taken) begin
               targetArr_r[resIdx_s] <= res_target[31:2];
            end
         end else if (res_taken) begin
            tagArr_r[resIdx_s]    <= resTag_s;
            targetArr_r[resIdx_s] <= res_target[31:2];
            ctrArr_r[resIdx_s]    <= CTR_INIT;
         end
      end
   end

   // Sequencer: exc_flush > stall hold > bp_flush > PENDING > lookup
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         pendTarget_r <= '0;
      end else if (exc_flush) begin
         state_r      <= IDLE;
         pendTarget_r <= '0;
      end else if (stall) begin
         state_r      <= state_r;
         pendTarget_r <= pendTarget_r;
      end else if (bpFlush_s) begin
         state_r      <= IDLE;
      end else begin
         case (state_r)
            PENDING: state_r <= IDLE;
            IDLE: begin
               if (lookTaken_s) begin
                  state_r      <= PENDING;
                  pendTarget_r <= lookEntry_s.target;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor_bht
// Scoreboard bench: the stimulus task computes each cycle's expected outputs
// from a table-of-records reference model and queues them; a negedge monitor
// pops and compares.
// ----------------------------------------------------------------------------
module tb_branch_predictor_bht;

   localparam int ENTRIES  = 64;
   localparam int CTR_BITS = 2;
   localparam int TAG_BITS = 8;
   localparam int IDX_BITS = 6;
   localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
   localparam int CTR_INIT = 1 << (CTR_BITS - 1);

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        exc_flush;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        pred_taken;
   logic        res_valid;
   logic [31:0] res_pc;
   logic        res_taken;
   logic [31:0] res_target;
   logic        res_pred_taken;
   logic        bp_flush;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   branch_predictor_bht #(
      .ENTRIES  (ENTRIES),
      .CTR_BITS (CTR_BITS),
      .TAG_BITS (TAG_BITS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .exc_flush      (exc_flush),
      .pc             (pc),
      .next_pc        (next_pc),
      .pred_taken     (pred_taken),
      .res_valid      (res_valid),
      .res_pc         (res_pc),
      .res_taken      (res_taken),
      .res_target     (res_target),
      .res_pred_taken (res_pred_taken),
      .bp_flush       (bp_flush),
      .redirect_pc    (redirect_pc)
   );

   typedef struct {
      logic [31:0] nextPc;
      logic        predTaken;
      logic        bpFlush;
      logic [31:0] redirectPc;
   } exp_t;

   exp_t expQ[$];
   exp_t mon;
   int   total = 0;
   int   bad   = 0;

   // Reference model: entries present in the maps are the valid ones.
   int unsigned mTag[int];
   logic [31:0] mTarget[int];
   int          mCtr[int];
   bit          mPending;
   logic [31:0] mPendTarget;

   function automatic int idxOf(input logic [31:0] a);
      return int'((a >> 2) % ENTRIES);
   endfunction

   function automatic int unsigned tagOf(input logic [31:0] a);
      return (a >> (IDX_BITS + 2)) % (1 << TAG_BITS);
   endfunction

   function automatic bit modelHit(input logic [31:0] a);
      int i;
      i = idxOf(a);
      return mTag.exists(i) && (mTag[i] == tagOf(a));
   endfunction

   function automatic bit modelTaken(input logic [31:0] a);
      return modelHit(a) && (mCtr[idxOf(a)] >= CTR_INIT);
   endfunction

   task automatic modelReset();
      mTag.delete();
      mTarget.delete();
      mCtr.delete();
      mPending    = 1'b0;
      mPendTarget = 32'd0;
   endtask

   task automatic step(input logic [31:0] p, input logic st, input logic ex,
                       input logic rv, input logic [31:0] rpc, input logic rt,
                       input logic [31:0] rtgt, input logic rpt);
      exp_t        e;
      bit          lookTaken;
      bit          hitR;
      bit          wrongTgt;
      bit          flush;
      int          ri;
      logic [31:0] pendCand;
      pc = p; stall = st; exc_flush = ex; res_valid = rv;
      res_pc = rpc; res_taken = rt; res_target = rtgt; res_pred_taken = rpt;
      lookTaken = modelTaken(p);
      pendCand  = lookTaken ? mTarget[idxOf(p)] : 32'd0;
      if (mPending) begin
         e.nextPc    = mPendTarget;
         e.predTaken = 1'b0;
      end else begin
         e.nextPc    = p + 32'd4;
         e.predTaken = lookTaken && !st && !ex;
      end
      ri       = idxOf(rpc);
      hitR     = modelHit(rpc);
      wrongTgt = rt && rpt && !(hitR && (mTarget[ri] == (rtgt & ~32'd3)));
      flush    = rv && ((rt != rpt) || wrongTgt);
      e.bpFlush    = flush;
      e.redirectPc = rt ? rtgt : rpc + 32'd8;
      expQ.push_back(e);
      @(posedge clk);
      if (rv && !st && !ex) begin
         if (hitR) begin
            if (rt) begin
               mCtr[ri]    = (mCtr[ri] + 1 > CTR_MAX) ? CTR_MAX : mCtr[ri] + 1;
               mTarget[ri] = rtgt & ~32'd3;
            end else begin
               mCtr[ri] = (mCtr[ri] - 1 < 0) ? 0 : mCtr[ri] - 1;
            end
         end else if (rt) begin
            mTag[ri]    = tagOf(rpc);
            mTarget[ri] = rtgt & ~32'd3;
            mCtr[ri]    = CTR_INIT;
         end
      end
      if (ex) begin
         mPending    = 1'b0;
         mPendTarget = 32'd0;
      end else if (!st) begin
         if (flush || mPending) begin
            mPending = 1'b0;
         end else if (lookTaken) begin
            mPending    = 1'b1;
            mPendTarget = pendCand;
         end
      end
      #1;
   endtask

   task automatic fetch(input logic [31:0] p);
      step(p, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic resolve(input logic [31:0] p, input logic [31:0] rpc,
                          input logic rt, input logic [31:0] rtgt, input logic rpt);
      step(p, 1'b0, 1'b0, 1'b1, rpc, rt, rtgt, rpt);
   endtask

   // Monitor: compare every presented output against the queued expectation
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         mon = expQ.pop_front();
         total++;
         if (next_pc !== mon.nextPc) begin
            bad++;
            $display("FAIL next_pc pc=%h got=%h want=%h", pc, next_pc, mon.nextPc);
         end
         total++;
         if (pred_taken !== mon.predTaken) begin
            bad++;
            $display("FAIL pred_taken pc=%h got=%b want=%b", pc, pred_taken, mon.predTaken);
         end
         total++;
         if (bp_flush !== mon.bpFlush) begin
            bad++;
            $display("FAIL bp_flush res_pc=%h got=%b want=%b", res_pc, bp_flush, mon.bpFlush);
         end
         if (mon.bpFlush) begin
            total++;
            if (redirect_pc !== mon.redirectPc) begin
               bad++;
               $display("FAIL redirect_pc got=%h want=%h", redirect_pc, mon.redirectPc);
            end
         end
      end
   end

   localparam logic [31:0] BR   = 32'h8000_0100;
   localparam logic [31:0] TGT  = 32'h8000_0200;
   localparam logic [31:0] ALIA = 32'h8000_1100;

   initial begin
      logic [31:0] pool [8];
      logic [31:0] tgts [4];
      logic [31:0] rp;
      logic        rt;
      logic        rpt;
      pool[0] = BR;           pool[1] = ALIA;         pool[2] = 32'h8000_0104;
      pool[3] = 32'h8000_0300; pool[4] = 32'h8000_2104; pool[5] = 32'h8000_0108;
      pool[6] = 32'h8000_2100; pool[7] = 32'h8000_0304;
      tgts[0] = TGT; tgts[1] = 32'h8000_0400; tgts[2] = 32'h8000_1000; tgts[3] = 32'h8000_0302;

      rst = 1'b1; stall = 1'b0; exc_flush = 1'b0; pc = 32'd0; res_valid = 1'b0;
      res_pc = 32'd0; res_taken = 1'b0; res_target = 32'd0; res_pred_taken = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Post-reset: no hits across 8 PCs
      for (int i = 0; i < 8; i++) fetch(32'hBFC0_0000 + 32'(i * 4));

      // First training: mispredict flush, then predicted-taken with delay slot
      resolve(32'h8000_0010, BR, 1'b1, TGT, 1'b0);
      fetch(BR);
      fetch(BR + 32'd4);
      fetch(TGT);

      // Saturate to 3, then walk back down
      resolve(32'h8000_0020, BR, 1'b1, TGT, 1'b1);
      resolve(32'h8000_0020, BR, 1'b1, TGT, 1'b1);
      resolve(32'h8000_0020, BR, 1'b0, TGT, 1'b1);
      fetch(BR);
      fetch(BR + 32'd4);
      resolve(32'h8000_0020, BR, 1'b0, TGT, 1'b1);
      fetch(BR);

      // Aliasing: same index, different tag misses
      resolve(32'h8000_0020, BR, 1'b1, TGT, 1'b0);
      fetch(ALIA);

      // PENDING held across a 3-cycle stall
      fetch(BR);
      for (int i = 0; i < 3; i++) step(BR + 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      fetch(BR + 32'd4);
      fetch(TGT);

      // exc_flush while PENDING returns to sequential fetch
      fetch(BR);
      step(BR + 32'd4, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      fetch(32'hBFC0_0180);

      // exc_flush with a simultaneous mispredict: no training
      step(32'h8000_0030, 1'b0, 1'b1, 1'b1, BR, 1'b0, 32'd0, 1'b1);
      fetch(BR);
      fetch(BR + 32'd4);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rp  = pool[$urandom_range(7)];
         rt  = 1'($urandom_range(1));
         rpt = ($urandom_range(1) == 0) ? modelTaken(rp) : 1'($urandom_range(1));
         step(($urandom_range(3) == 0) ? {20'h80000, 10'($urandom), 2'b00}
                                       : pool[$urandom_range(7)],
              1'($urandom_range(7) == 0), 1'($urandom_range(15) == 0),
              1'($urandom_range(2) == 0), rp, rt, tgts[$urandom_range(3)], rpt);
      end

      @(negedge clk);
      #1;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
